// File: rtl/alut_pkg13.sv
// ---------------------------------------------------------------------------
// alut_pkg13
// Shared definitions for the ALUT age checker: entry field positions, the
// aging-sweep command code and the state encodings of both FSMs.
// ---------------------------------------------------------------------------
package alut_pkg13;

    localparam int ADDR_W = 8;    // ALUT index width
    localparam int DATA_W = 83;   // ALUT entry width
    localparam int TIME_W = 32;   // timestamp / age width

    // Entry layout: [82]=valid [81:50]=time [49:48]=port [47:0]=addr
    localparam int VALID_BIT = 82;
    localparam int TIME_MSB  = 81;
    localparam int TIME_LSB  = 50;
    localparam int PORT_MSB  = 49;
    localparam int PORT_LSB  = 48;
    localparam int ADDR_MSB  = 47;

    localparam logic [1:0] CMD_AGE_SWEEP = 2'b11;

    typedef enum logic [1:0] {
        CK_IDLE = 2'd0,
        CK_CALC = 2'd1,
        CK_DONE = 2'd2
    } ck_state_e;

    typedef enum logic [2:0] {
        SW_IDLE  = 3'd0,
        SW_READ  = 3'd1,
        SW_WAIT  = 3'd2,
        SW_EVAL  = 3'd3,
        SW_WRITE = 3'd4
    } sw_state_e;

endpackage

// File: rtl/alut_age_cmp13.sv
// ---------------------------------------------------------------------------
// alut_age_cmp13
// Registered age compare: age = curr_time - stamp (modulo 2**TIME_W, so a
// wrapped time base still yields the true age), in date iff age <= max_age.
// The result register only loads while en_i is high and holds otherwise.
// Ports:
//   pclk13, n_p_reset13  clock, asynchronous active-low reset
//   en_i                 load enable for the result register
//   curr_time_i          current time
//   stamp_i              entry timestamp
//   max_age_i            maximum permitted age (inclusive)
//   in_date_o            registered compare result
// ---------------------------------------------------------------------------
module alut_age_cmp13
    import alut_pkg13::*;
(
    input  logic              pclk13,
    input  logic              n_p_reset13,
    input  logic              en_i,
    input  logic [TIME_W-1:0] curr_time_i,
    input  logic [TIME_W-1:0] stamp_i,
    input  logic [TIME_W-1:0] max_age_i,
    output logic              in_date_o
);

    logic [TIME_W-1:0] age;
    logic              in_date_d;
    logic              in_date_q;

    assign age       = curr_time_i - stamp_i;
    assign in_date_d = (age <= max_age_i);

    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            in_date_q <= 1'b0;
        end else if (en_i) begin
            in_date_q <= in_date_d;
        end
    end

    assign in_date_o = in_date_q;

endmodule

// File: rtl/alut_age_checker13.sv
// ---------------------------------------------------------------------------
// alut_age_checker13
// Services age-check requests from the ALUT address checker and runs a
// software-triggered aging sweep that clears the valid bit of stale entries.
// Ports:
//   pclk13, n_p_reset13       clock, asynchronous active-low reset
//   command                   2'b11 starts an aging sweep (level sampled)
//   curr_time13               free-running time base
//   best_bfr_age13            maximum permitted age (inclusive)
//   check_age13/last_accessed13  age-check request and entry timestamp
//   add_check_active13        address checker owns the memory port
//   mem_read_data_age13       memory read data (1-cycle synchronous read)
//   age_confirmed13/age_ok13  one-cycle result strobe and result
//   sweep_active13            sweep in progress
//   mem_addr_age13, mem_write_age13, mem_write_data_age13  memory port
//   lst_inv_addr_cmd13/lst_inv_port_cmd13  last entry invalidated
//   inval_count13             entries invalidated in the latest sweep
// Memory handshake: mem_addr_age13 is registered and held; the memory
// returns data for it one clock later. A write happens in every cycle where
// mem_write_age13 is high, at mem_addr_age13 with mem_write_data_age13.
// ---------------------------------------------------------------------------
module alut_age_checker13
    import alut_pkg13::*;
(
    input  logic              pclk13,
    input  logic              n_p_reset13,
    input  logic [1:0]        command,
    input  logic [TIME_W-1:0] curr_time13,
    input  logic [TIME_W-1:0] best_bfr_age13,
    input  logic              check_age13,
    input  logic [TIME_W-1:0] last_accessed13,
    input  logic              add_check_active13,
    input  logic [DATA_W-1:0] mem_read_data_age13,
    output logic              age_confirmed13,
    output logic              age_ok13,
    output logic              sweep_active13,
    output logic [ADDR_W-1:0] mem_addr_age13,
    output logic              mem_write_age13,
    output logic [DATA_W-1:0] mem_write_data_age13,
    output logic [ADDR_MSB:0] lst_inv_addr_cmd13,
    output logic [1:0]        lst_inv_port_cmd13,
    output logic [ADDR_W:0]   inval_count13
);

    // ---------------- check path ----------------
    ck_state_e         ck_state_q, ck_state_d;
    logic [TIME_W-1:0] ck_curr_q, ck_last_q;
    logic              ck_in_date;
    logic              age_ok_q;

    alut_age_cmp13 u_ck_cmp (
        .pclk13      (pclk13),
        .n_p_reset13 (n_p_reset13),
        .en_i        (ck_state_q == CK_CALC),
        .curr_time_i (ck_curr_q),
        .stamp_i     (ck_last_q),
        .max_age_i   (best_bfr_age13),
        .in_date_o   (ck_in_date)
    );

    always_comb begin
        ck_state_d = ck_state_q;
        case (ck_state_q)
            CK_IDLE: if (check_age13) ck_state_d = CK_CALC;
            CK_CALC: ck_state_d = CK_DONE;
            CK_DONE: ck_state_d = CK_IDLE;
            default: ck_state_d = CK_IDLE;
        endcase
    end

    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            ck_state_q <= CK_IDLE;
            ck_curr_q  <= '0;
            ck_last_q  <= '0;
            age_ok_q   <= 1'b0;
        end else begin
            ck_state_q <= ck_state_d;
            if (ck_state_q == CK_IDLE && check_age13) begin
                ck_curr_q <= curr_time13;
                ck_last_q <= last_accessed13;
            end
            if (ck_state_q == CK_DONE) age_ok_q <= ck_in_date;
        end
    end

    // Result is presented straight from the compare during the strobe and
    // then held in age_ok_q until the next strobe.
    assign age_confirmed13 = (ck_state_q == CK_DONE);
    assign age_ok13        = (ck_state_q == CK_DONE) ? ck_in_date : age_ok_q;

    // ---------------- sweep path ----------------
    sw_state_e         sw_state_q, sw_state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_MSB:0] lst_addr_q, lst_addr_d;
    logic [1:0]        lst_port_q, lst_port_d;
    logic [ADDR_W:0]   inval_q, inval_d;
    logic              paused_q, paused_d;
    logic              frozen;
    logic              advance;
    logic              sw_in_date;

    // Address is already idx while in SW_READ, so data is valid in SW_WAIT
    // (compare loads) and still valid in SW_EVAL alongside the result.
    alut_age_cmp13 u_sw_cmp (
        .pclk13      (pclk13),
        .n_p_reset13 (n_p_reset13),
        .en_i        (sw_state_q == SW_WAIT && !add_check_active13),
        .curr_time_i (curr_time13),
        .stamp_i     (mem_read_data_age13[TIME_MSB:TIME_LSB]),
        .max_age_i   (best_bfr_age13),
        .in_date_o   (sw_in_date)
    );

    assign frozen = add_check_active13 && (sw_state_q != SW_IDLE);

    always_comb begin
        sw_state_d  = sw_state_q;
        idx_d       = idx_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        lst_addr_d  = lst_addr_q;
        lst_port_d  = lst_port_q;
        inval_d     = inval_q;
        paused_d    = paused_q;
        advance     = 1'b0;

        if (frozen) begin
            paused_d = 1'b1;
        end else begin
            paused_d = 1'b0;
            case (sw_state_q)
                SW_IDLE: begin
                    if (command == CMD_AGE_SWEEP && !add_check_active13) begin
                        idx_d      = '0;
                        mem_addr_d = '0;
                        inval_d    = '0;
                        sw_state_d = SW_READ;
                    end
                end
                SW_READ: begin
                    mem_addr_d  = idx_q;
                    mem_write_d = 1'b0;
                    sw_state_d  = SW_WAIT;
                end
                // After a pause the port was used by the address checker,
                // so the read data is refetched.
                SW_WAIT: sw_state_d = paused_q ? SW_READ : SW_EVAL;
                SW_EVAL: begin
                    if (paused_q) begin
                        sw_state_d = SW_READ;
                    end else if (mem_read_data_age13[VALID_BIT] && !sw_in_date) begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = {1'b0, mem_read_data_age13[TIME_MSB:0]};
                        sw_state_d  = SW_WRITE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                SW_WRITE: begin
                    mem_write_d = 1'b0;
                    lst_addr_d  = mem_wdata_q[ADDR_MSB:0];
                    lst_port_d  = mem_wdata_q[PORT_MSB:PORT_LSB];
                    inval_d     = inval_q + 1'b1;
                    advance     = 1'b1;
                end
                default: sw_state_d = SW_IDLE;
            endcase

            if (advance) begin
                if (idx_q == '1) begin
                    sw_state_d = SW_IDLE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_addr_d = idx_q + 1'b1;
                    sw_state_d = SW_READ;
                end
            end
        end
    end

    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            sw_state_q  <= SW_IDLE;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            lst_addr_q  <= '0;
            lst_port_q  <= '0;
            inval_q     <= '0;
            paused_q    <= 1'b0;
        end else begin
            sw_state_q  <= sw_state_d;
            idx_q       <= idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            lst_addr_q  <= lst_addr_d;
            lst_port_q  <= lst_port_d;
            inval_q     <= inval_d;
            paused_q    <= paused_d;
        end
    end

    // A pending write stays armed across a pause and is masked while the
    // address checker owns the port.
    assign mem_write_age13      = mem_write_q && !add_check_active13;
    assign sweep_active13       = (sw_state_q != SW_IDLE);
    assign mem_addr_age13       = mem_addr_q;
    assign mem_write_data_age13 = mem_wdata_q;
    assign lst_inv_addr_cmd13   = lst_addr_q;
    assign lst_inv_port_cmd13   = lst_port_q;
    assign inval_count13        = inval_q;

endmodule

// File: tb/tb_alut_age_checker13.sv
module tb_alut_age_checker13;

    logic        pclk13 = 1'b0;
    logic        n_p_reset13 = 1'b0;
    logic [1:0]  command = 2'b00;
    logic [31:0] curr_time13 = '0;
    logic [31:0] best_bfr_age13 = '0;
    logic        check_age13 = 1'b0;
    logic [31:0] last_accessed13 = '0;
    logic        add_check_active13 = 1'b0;
    logic [82:0] mem_read_data_age13;
    logic        age_confirmed13;
    logic        age_ok13;
    logic        sweep_active13;
    logic [7:0]  mem_addr_age13;
    logic        mem_write_age13;
    logic [82:0] mem_write_data_age13;
    logic [47:0] lst_inv_addr_cmd13;
    logic [1:0]  lst_inv_port_cmd13;
    logic [8:0]  inval_count13;

    int checks = 0;
    int passed = 0;

    logic [82:0] mem [256];
    logic [7:0]  wr_addr_log[$];
    logic [82:0] wr_data_log[$];
    logic [7:0]  exp_q[$];

    localparam logic [82:0] E5   = {1'b1, 32'd500, 2'd1, 48'h0000_1111_0005};
    localparam logic [82:0] E7   = {1'b1, 32'd950, 2'd3, 48'h0000_0000_7777};
    localparam logic [82:0] E200 = {1'b1, 32'd10,  2'd2, 48'hABCD_EF01_2345};

    // clock / reset
    always #5 pclk13 = ~pclk13;

    alut_age_checker13 dut (
        .pclk13               (pclk13),
        .n_p_reset13          (n_p_reset13),
        .command              (command),
        .curr_time13          (curr_time13),
        .best_bfr_age13       (best_bfr_age13),
        .check_age13          (check_age13),
        .last_accessed13      (last_accessed13),
        .add_check_active13   (add_check_active13),
        .mem_read_data_age13  (mem_read_data_age13),
        .age_confirmed13      (age_confirmed13),
        .age_ok13             (age_ok13),
        .sweep_active13       (sweep_active13),
        .mem_addr_age13       (mem_addr_age13),
        .mem_write_age13      (mem_write_age13),
        .mem_write_data_age13 (mem_write_data_age13),
        .lst_inv_addr_cmd13   (lst_inv_addr_cmd13),
        .lst_inv_port_cmd13   (lst_inv_port_cmd13),
        .inval_count13        (inval_count13)
    );

    // Shared ALUT memory: while the address checker owns the port it reads
    // entry 0, so the sweep must refetch its data after a pause.
    always @(posedge pclk13) begin
        if (mem_write_age13) begin
            mem[mem_addr_age13] <= mem_write_data_age13;
            wr_addr_log.push_back(mem_addr_age13);
            wr_data_log.push_back(mem_write_data_age13);
        end
        mem_read_data_age13 <= add_check_active13 ? mem[0] : mem[mem_addr_age13];
    end

    // scoreboard compare
    task automatic check(input string tag, input logic [82:0] obs, input logic [82:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk13);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, 32'd0, 2'd0, 48'(i)};
        mem[5]   = E5;
        mem[7]   = E7;
        mem[200] = E200;
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    // driver: one check_age13 pulse, verify strobe timing and result
    task automatic age_check(input string tag, input logic [31:0] curr, input logic [31:0] last,
                             input logic [31:0] max, input logic exp_ok);
        curr_time13     = curr;
        last_accessed13 = last;
        best_bfr_age13  = max;
        check_age13     = 1'b1;
        tick();
        check_age13 = 1'b0;
        check({tag, "_t1_conf"}, 83'(age_confirmed13), 83'(1'b0));
        tick();
        check({tag, "_t2_conf"}, 83'(age_confirmed13), 83'(1'b1));
        check({tag, "_t2_ok"}, 83'(age_ok13), 83'(exp_ok));
        tick();
        check({tag, "_t3_conf"}, 83'(age_confirmed13), 83'(1'b0));
        check({tag, "_t3_hold"}, 83'(age_ok13), 83'(exp_ok));
    endtask

    task automatic start_sweep();
        command = 2'b11;
        tick();
        command = 2'b00;
        check("sweep_start", 83'(sweep_active13), 83'(1'b1));
    endtask

    task automatic wait_addr(input logic [7:0] a);
        int n = 0;
        while (mem_addr_age13 !== a && n < 3000) begin
            tick();
            n++;
        end
        check("wait_addr", 83'(mem_addr_age13), 83'(a));
    endtask

    task automatic wait_done();
        int n = 0;
        while (sweep_active13 !== 1'b0 && n < 4000) begin
            tick();
            n++;
        end
        check("sweep_done", 83'(sweep_active13), 83'(1'b0));
    endtask

    task automatic check_sweep_result(input string tag);
        check({tag, "_inval"}, 83'(inval_count13), 83'(9'd2));
        check({tag, "_lst_addr"}, 83'(lst_inv_addr_cmd13), 83'(48'hABCD_EF01_2345));
        check({tag, "_lst_port"}, 83'(lst_inv_port_cmd13), 83'(2'd2));
        check({tag, "_end_addr"}, 83'(mem_addr_age13), 83'(8'd255));
        check({tag, "_nwr"}, 83'(wr_addr_log.size()), 83'(2));
        exp_q = '{8'd5, 8'd200};
        for (int i = 0; i < 2 && i < wr_addr_log.size(); i++) begin
            check({tag, "_wr_addr"}, 83'(wr_addr_log[i]), 83'(exp_q[i]));
        end
        if (wr_data_log.size() >= 2) begin
            check({tag, "_wr_data5"}, wr_data_log[0], {1'b0, E5[81:0]});
            check({tag, "_wr_data200"}, wr_data_log[1], {1'b0, E200[81:0]});
        end
        check({tag, "_mem7"}, mem[7], E7);
        check({tag, "_mem5_valid"}, 83'(mem[5][82]), 83'(1'b0));
    endtask

    initial begin
        int conf_cnt;

        // reset state
        preload();
        repeat (3) tick();
        check("rst_conf", 83'(age_confirmed13), 83'(1'b0));
        check("rst_ok", 83'(age_ok13), 83'(1'b0));
        check("rst_active", 83'(sweep_active13), 83'(1'b0));
        check("rst_addr", 83'(mem_addr_age13), 83'(8'd0));
        check("rst_we", 83'(mem_write_age13), 83'(1'b0));
        check("rst_wdata", mem_write_data_age13, 83'(0));
        check("rst_inval", 83'(inval_count13), 83'(9'd0));
        n_p_reset13 = 1'b1;
        tick();

        // check path: in-date, boundary out of date, wrap, zero max
        age_check("age60", 32'd100, 32'd40, 32'd60, 1'b1);
        age_check("age59", 32'd100, 32'd40, 32'd59, 1'b0);
        age_check("wrap", 32'h0000_0010, 32'hFFFF_FFF0, 32'h20, 1'b1);
        age_check("zero_max_pass", 32'd77, 32'd77, 32'd0, 1'b1);
        age_check("zero_max_fail", 32'd78, 32'd77, 32'd0, 1'b0);

        // pulses every 2nd cycle: accepted at 0,4,8,12 -> 4 strobes
        conf_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            check_age13 = (i < 16) && (i % 2 == 0);
            tick();
            if (age_confirmed13) conf_cnt++;
        end
        check_age13 = 1'b0;
        check("repeat_conf_cnt", 83'(conf_cnt), 83'(4));

        // full sweep with a concurrent age check
        curr_time13    = 32'd1000;
        best_bfr_age13 = 32'd100;
        preload();
        start_sweep();
        repeat (20) tick();
        age_check("concurrent", 32'd1000, 32'd850, 32'd100, 1'b0);
        wait_done();
        check_sweep_result("sweep1");

        // pause while evaluating entry 200; data must be refetched
        preload();
        start_sweep();
        wait_addr(8'd200);
        tick();
        tick();
        add_check_active13 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pause_we", 83'(mem_write_age13), 83'(1'b0));
            check("pause_addr", 83'(mem_addr_age13), 83'(8'd200));
        end
        add_check_active13 = 1'b0;
        wait_done();
        check_sweep_result("sweep2");

        // reset at idx 100 aborts; next sweep restarts from idx 0
        preload();
        start_sweep();
        wait_addr(8'd100);
        n_p_reset13 = 1'b0;
        #1;
        check("abort_active", 83'(sweep_active13), 83'(1'b0));
        check("abort_inval", 83'(inval_count13), 83'(9'd0));
        check("abort_lst_addr", 83'(lst_inv_addr_cmd13), 83'(48'd0));
        check("abort_lst_port", 83'(lst_inv_port_cmd13), 83'(2'd0));
        check("abort_addr", 83'(mem_addr_age13), 83'(8'd0));
        check("abort_we", 83'(mem_write_age13), 83'(1'b0));
        #20;
        n_p_reset13 = 1'b1;
        tick();
        preload();
        start_sweep();
        wait_done();
        check_sweep_result("sweep3");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
